// File: rtl/l23_rd_stream_ctrl.sv
// rtl/l23_rd_stream_ctrl.sv - packet buffer read side to AXI-Stream master, one character per beat
module l23_rd_stream_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_greenflag,
  input  logic              tlast_flag,
  input  logic [DATA_W-1:0] ram_q,
  output logic              rd_char_incr,
  output logic              rd_char_setzero,
  output logic              rd_line_incr,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  // One read in flight: RAM data arrives the cycle after issue.
  logic              inflight;
  logic              inflight_last;

  // Two-entry output FIFO; entry 0 is the head driving the stream.
  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] fifo_data0;
  logic [DATA_W-1:0] fifo_data1;
  logic              fifo_last0;
  logic              fifo_last1;

  logic              pop;
  logic              push;
  logic              issue;
  logic              line_done;
  logic [2:0]        credit_used;

  // tvalid comes only from the registered FIFO count, never from tready.
  assign m_axis_tvalid = (fifo_cnt != 2'd0);
  assign m_axis_tdata  = fifo_data0;
  assign m_axis_tlast  = fifo_last0 & m_axis_tvalid;

  assign pop         = m_axis_tvalid & m_axis_tready;
  assign push        = inflight;
  // Slots already claimed after this cycle's pop; at most two may be outstanding.
  assign credit_used = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign line_done   = (state == DRAIN) & pop & m_axis_tlast;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; greenflag is only consulted in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_greenflag) state_nxt = STREAM;
      STREAM:  if (issue && tlast_flag) state_nxt = DRAIN;
      DRAIN:   if (line_done) state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: read issue under credit, line release on the accepted tlast beat
  always_comb begin
    issue           = (state == STREAM) && (credit_used < 3'd2);
    rd_char_incr    = issue;
    rd_line_incr    = line_done;
    rd_char_setzero = line_done;
  end

  // In-flight read tracking; carries the end-of-line mark alongside the data
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_last <= tlast_flag;
    end
  end

  // Output FIFO; the head only changes on a pop, keeping tdata/tlast stable under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt   <= 2'd0;
      fifo_data0 <= '0;
      fifo_data1 <= '0;
      fifo_last0 <= 1'b0;
      fifo_last1 <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            fifo_data0 <= ram_q;
            fifo_last0 <= inflight_last;
          end else begin
            fifo_data1 <= ram_q;
            fifo_last1 <= inflight_last;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_data0 <= fifo_data1;
          fifo_last0 <= fifo_last1;
          fifo_cnt   <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo_data0 <= ram_q;
            fifo_last0 <= inflight_last;
          end else begin
            fifo_data0 <= fifo_data1;
            fifo_last0 <= fifo_last1;
            fifo_data1 <= ram_q;
            fifo_last1 <= inflight_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l23_rd_stream_ctrl.sv
// tb/tb_l23_rd_stream_ctrl.sv - directed and random bench for l23_rd_stream_ctrl with pointer/RAM model
module tb_l23_rd_stream_ctrl;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_greenflag;
  logic              tlast_flag;
  logic [DATA_W-1:0] ram_q = '0;
  logic              rd_char_incr;
  logic              rd_char_setzero;
  logic              rd_line_incr;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b0;

  l23_rd_stream_ctrl #(.DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .rd_greenflag    (rd_greenflag),
    .tlast_flag      (tlast_flag),
    .ram_q           (ram_q),
    .rd_char_incr    (rd_char_incr),
    .rd_char_setzero (rd_char_setzero),
    .rd_line_incr    (rd_line_incr),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready)
  );

  always #5 clk = ~clk;

  // Packet RAM and line store, filled by the stimulus
  logic [7:0] mem [0:65535];
  int line_len  [0:511];
  int line_base [0:511];
  int lines_stored = 0;
  int next_base    = 0;

  // Pointer block model, owned by this process
  int line_rd  = 0;
  int char_ptr = 0;
  int cyc      = 0;

  assign rd_greenflag = (line_rd < lines_stored);
  assign tlast_flag   = rd_greenflag && (char_ptr == line_len[line_rd] - 1);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      char_ptr <= 0;
      line_rd  <= lines_stored;
    end else begin
      if (rd_char_incr) ram_q <= mem[line_base[line_rd] + char_ptr];
      if (rd_char_setzero) char_ptr <= 0;
      else if (rd_char_incr) char_ptr <= char_ptr + 1;
      if (rd_line_incr) line_rd <= line_rd + 1;
    end
  end

  // Scoreboard and event logs
  logic [8:0] exp_q [$];
  int incr_cyc [$];
  int beat_cyc [$];
  int li_cyc   [$];
  int tlast_beats;
  int first_vld;
  bit hold = 1'b0;
  logic [8:0] hold_word;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    incr_cyc.delete();
    beat_cyc.delete();
    li_cyc.delete();
    tlast_beats = 0;
    first_vld   = -1;
  endtask

  task automatic load_line(input int n, input bit rnd);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom) : 8'(8'hA0 + i);
      mem[next_base + i] = d;
      exp_q.push_back({(i == n - 1), d});
    end
    line_len[lines_stored]  = n;
    line_base[lines_stored] = next_base;
    next_base    = next_base + n;
    lines_stored = lines_stored + 1;
  endtask

  // One cycle: drive tready after the falling edge, then check and log outputs
  task automatic step(input bit rdy);
    bit pop;
    logic [8:0] w;
    @(negedge clk);
    m_axis_tready = rdy;
    #1;
    pop = m_axis_tvalid & m_axis_tready;
    if (hold) begin
      chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
      chk("hold_word", 32'({m_axis_tlast, m_axis_tdata}), 32'(hold_word));
    end
    hold      = m_axis_tvalid & ~m_axis_tready;
    hold_word = {m_axis_tlast, m_axis_tdata};
    if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
    if (pop) begin
      chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(w));
      end
      beat_cyc.push_back(cyc);
      if (m_axis_tlast) tlast_beats++;
    end
    chk("line_incr_on_tlast", 32'(rd_line_incr), 32'(pop & m_axis_tlast));
    chk("setzero_with_line_incr", 32'(rd_char_setzero), 32'(pop & m_axis_tlast));
    if (rd_char_incr) incr_cyc.push_back(cyc);
    if (rd_line_incr) li_cyc.push_back(cyc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_incr"},    32'(rd_char_incr), 32'd0);
    chk({tag, "_setzero"}, 32'(rd_char_setzero), 32'd0);
    chk({tag, "_line"},    32'(rd_line_incr), 32'd0);
    chk({tag, "_tvalid"},  32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tlast"},   32'(m_axis_tlast), 32'd0);
    chk({tag, "_tdata"},   32'(m_axis_tdata), 32'd0);
  endtask

  initial begin
    int t;
    int k;
    int n_early;
    clr();

    // Reset state
    rst = 1'b1;
    repeat (3) step(1'b0);
    chk_outputs_zero("reset");
    rst = 1'b0;
    run(2);

    // 4-char line, tready high
    clr();
    t = cyc;
    load_line(4, 1'b0);
    run(10);
    chk("l4_incr_count", 32'(incr_cyc.size()), 32'd4);
    for (int i = 0; i < incr_cyc.size(); i++) chk("l4_incr_cyc", 32'(incr_cyc[i]), 32'(t + 1 + i));
    chk("l4_beat_count", 32'(beat_cyc.size()), 32'd4);
    for (int i = 0; i < beat_cyc.size(); i++) chk("l4_beat_cyc", 32'(beat_cyc[i]), 32'(t + 3 + i));
    chk("l4_li_count", 32'(li_cyc.size()), 32'd1);
    chk("l4_li_cyc", 32'(li_cyc[0]), 32'(t + 6));
    chk("l4_tlast_count", 32'(tlast_beats), 32'd1);
    chk("l4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Same line with tready low over t+2..t+10
    clr();
    t = cyc;
    load_line(4, 1'b0);
    for (int i = 0; i < 24; i++) begin
      k = cyc + 1;
      step(!(k >= t + 2 && k <= t + 10));
    end
    n_early = 0;
    foreach (incr_cyc[i]) if (incr_cyc[i] <= t + 10) n_early++;
    chk("bp_incr_early", 32'(n_early), 32'd2);
    chk("bp_incr0", 32'(incr_cyc[0]), 32'(t + 1));
    chk("bp_incr1", 32'(incr_cyc[1]), 32'(t + 2));
    chk("bp_incr_total", 32'(incr_cyc.size()), 32'd4);
    chk("bp_first_valid", 32'(first_vld), 32'(t + 3));
    chk("bp_first_beat", 32'(beat_cyc[0]), 32'(t + 11));
    chk("bp_beat_count", 32'(beat_cyc.size()), 32'd4);
    chk("bp_li_count", 32'(li_cyc.size()), 32'd1);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // 1-char line
    clr();
    load_line(1, 1'b1);
    run(10);
    chk("l1_incr_count", 32'(incr_cyc.size()), 32'd1);
    chk("l1_beat_count", 32'(beat_cyc.size()), 32'd1);
    chk("l1_tlast_count", 32'(tlast_beats), 32'd1);
    chk("l1_li_count", 32'(li_cyc.size()), 32'd1);

    // Two stored lines (3 and 2), back to back
    clr();
    t = cyc;
    load_line(3, 1'b1);
    load_line(2, 1'b1);
    run(20);
    chk("two_beat_count", 32'(beat_cyc.size()), 32'd5);
    chk("two_beat0", 32'(beat_cyc[0]), 32'(t + 3));
    chk("two_beat2", 32'(beat_cyc[2]), 32'(t + 5));
    chk("two_beat3", 32'(beat_cyc[3]), 32'(t + 10));
    chk("two_beat4", 32'(beat_cyc[4]), 32'(t + 11));
    chk("two_li_count", 32'(li_cyc.size()), 32'd2);
    chk("two_li0", 32'(li_cyc[0]), 32'(t + 5));
    chk("two_li1", 32'(li_cyc[1]), 32'(t + 11));
    chk("two_tlast_count", 32'(tlast_beats), 32'd2);
    chk("two_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset after 2 of 6 beats
    clr();
    load_line(6, 1'b1);
    for (int i = 0; i < 20 && beat_cyc.size() < 2; i++) step(1'b1);
    chk("rst_pre_beats", 32'(beat_cyc.size()), 32'd2);
    rst = 1'b1;
    step(1'b1);
    chk_outputs_zero("rst_mid");
    rst = 1'b0;
    exp_q.delete();
    run(4);
    chk("rst_no_li", 32'(li_cyc.size()), 32'd0);
    chk("rst_idle_valid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_idle_incr", 32'(rd_char_incr), 32'd0);
    clr();
    load_line(3, 1'b1);
    run(10);
    chk("rst_restart_beats", 32'(beat_cyc.size()), 32'd3);
    chk("rst_restart_li", 32'(li_cyc.size()), 32'd1);
    chk("rst_restart_sb_empty", 32'(exp_q.size()), 32'd0);

    // 200 lines, random length, random tready
    clr();
    for (int i = 0; i < 200; i++) begin
      if (i == 0) load_line(2048, 1'b1);
      else if (i == 1) load_line(1, 1'b1);
      else load_line($urandom_range(1, 48), 1'b1);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 60000) begin
      step(1'($urandom_range(0, 1)));
      k++;
    end
    run(8);
    chk("rand_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_li_count", 32'(li_cyc.size()), 32'd200);
    chk("rand_tlast_count", 32'(tlast_beats), 32'd200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
